// File: rtl/fractal_sync_cu_arbiter.sv
// Round-robin arbiter sharing one fractal_sync_1d request port among N_REQ local requesters.
// Tracks each requester's outstanding barrier and routes node wake/error responses back to it.
module fractal_sync_cu_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned AGGR_W = 6,
    parameter int unsigned ID_W   = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*AGGR_W-1:0] req_aggr_i,
    input  logic [N_REQ*ID_W-1:0]   req_id_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        wake_o,
    output logic [N_REQ-1:0]        error_o,
    output logic [N_REQ-1:0]        pending_o,
    output logic                    fsync_valid_o,
    output logic [AGGR_W-1:0]       fsync_aggr_o,
    output logic [ID_W-1:0]         fsync_id_o,
    input  logic                    fsync_ready_i,
    input  logic                    fsync_wake_i,
    input  logic                    fsync_error_i,
    input  logic [AGGR_W-1:0]       fsync_rsp_aggr_i,
    input  logic [ID_W-1:0]         fsync_rsp_id_i,
    output logic                    unmatched_o
);
    localparam int unsigned PtrW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q [N_REQ];
    logic [AGGR_W-1:0] aggr_q  [N_REQ];
    logic [ID_W-1:0]   id_q    [N_REQ];
    logic [PtrW-1:0]   rr_ptr_q;
    logic [PtrW-1:0]   owner_q;
    logic              fsync_valid_q;
    logic [AGGR_W-1:0] fsync_aggr_q;
    logic [ID_W-1:0]   fsync_id_q;
    logic [N_REQ-1:0]  wake_q, error_q;
    logic              unmatched_q;

    logic              issue_free, handshake, rsp_vld;
    logic              grant_vld;
    logic [PtrW-1:0]   grant_idx, cand;
    logic [N_REQ-1:0]  eligible, match;
    logic [AGGR_W-1:0] sel_aggr;
    logic [ID_W-1:0]   sel_id;

    assign handshake  = fsync_valid_q & fsync_ready_i;
    assign issue_free = ~fsync_valid_q | fsync_ready_i;
    assign rsp_vld    = fsync_wake_i | fsync_error_i;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i]  = (state_q[i] == StIdle) & req_valid_i[i];
            match[i]     = (state_q[i] == StWait) & rsp_vld & (aggr_q[i] == fsync_rsp_aggr_i) &
                           (id_q[i] == fsync_rsp_id_i);
            pending_o[i] = (state_q[i] != StIdle);
        end
    end

    // First eligible requester at or after rr_ptr, scanning cyclically.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PtrW'((int'(rr_ptr_q) + k) % N_REQ);
            if (!grant_vld && issue_free && rst_ni && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        req_ready_o = '0;
        if (grant_vld) req_ready_o[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_aggr = '0;
        sel_id   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready_o[i]) begin
                sel_aggr = req_aggr_i[i*AGGR_W +: AGGR_W];
                sel_id   = req_id_i[i*ID_W +: ID_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= StIdle;
                aggr_q[i]  <= '0;
                id_q[i]    <= '0;
            end
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            fsync_valid_q <= 1'b0;
            fsync_aggr_q  <= '0;
            fsync_id_q    <= '0;
            wake_q        <= '0;
            error_q       <= '0;
            unmatched_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                unique case (state_q[i])
                    StIdle: if (req_ready_o[i]) begin
                        state_q[i] <= StIssue;
                        aggr_q[i]  <= req_aggr_i[i*AGGR_W +: AGGR_W];
                        id_q[i]    <= req_id_i[i*ID_W +: ID_W];
                    end
                    StIssue: if (handshake && owner_q == PtrW'(i)) state_q[i] <= StWait;
                    StWait:  if (match[i]) state_q[i] <= StIdle;
                    default: state_q[i] <= StIdle;
                endcase
            end
            if (issue_free) begin
                fsync_valid_q <= grant_vld;
                if (grant_vld) begin
                    fsync_aggr_q <= sel_aggr;
                    fsync_id_q   <= sel_id;
                    owner_q      <= grant_idx;
                    rr_ptr_q     <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                end
            end
            // Error wins when both response strobes are raised.
            wake_q      <= match & {N_REQ{fsync_wake_i & ~fsync_error_i}};
            error_q     <= match & {N_REQ{fsync_error_i}};
            unmatched_q <= rsp_vld & ~|match;
        end
    end

    assign fsync_valid_o = fsync_valid_q;
    assign fsync_aggr_o  = fsync_aggr_q;
    assign fsync_id_o    = fsync_id_q;
    assign wake_o        = wake_q;
    assign error_o       = error_q;
    assign unmatched_o   = unmatched_q;

endmodule

// File: tb/tb_fractal_sync_cu_arbiter.sv
// Scoreboard bench: issued requests and responses are queued as expected, a monitor compares.
module tb_fractal_sync_cu_arbiter;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int IW = 5;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid_i;
    logic [N*AW-1:0] req_aggr_i;
    logic [N*IW-1:0] req_id_i;
    logic [N-1:0]    req_ready_o, wake_o, error_o, pending_o;
    logic            fsync_valid_o, fsync_ready_i, fsync_wake_i, fsync_error_i, unmatched_o;
    logic [AW-1:0]   fsync_aggr_o, fsync_rsp_aggr_i;
    logic [IW-1:0]   fsync_id_o, fsync_rsp_id_i;

    fractal_sync_cu_arbiter #(.N_REQ(N), .AGGR_W(AW), .ID_W(IW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_aggr_i       (req_aggr_i),
        .req_id_i         (req_id_i),
        .req_ready_o      (req_ready_o),
        .wake_o           (wake_o),
        .error_o          (error_o),
        .pending_o        (pending_o),
        .fsync_valid_o    (fsync_valid_o),
        .fsync_aggr_o     (fsync_aggr_o),
        .fsync_id_o       (fsync_id_o),
        .fsync_ready_i    (fsync_ready_i),
        .fsync_wake_i     (fsync_wake_i),
        .fsync_error_i    (fsync_error_i),
        .fsync_rsp_aggr_i (fsync_rsp_aggr_i),
        .fsync_rsp_id_i   (fsync_rsp_id_i),
        .unmatched_o      (unmatched_o)
    );

    always #5 clk = ~clk;

    logic [AW+IW-1:0] iss_q[$];
    logic [2*N:0]     rsp_q[$];  // {unmatched, error, wake}
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: issued requests and response pulses are popped and compared at negedge.
    initial begin
        logic [AW+IW-1:0] ei;
        logic [2*N:0]     er;
        forever begin
            @(negedge clk);
            if (rst_ni && fsync_valid_o && fsync_ready_i) begin
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got %0h expected none", {fsync_aggr_o, fsync_id_o});
                end else begin
                    ei = iss_q.pop_front();
                    chk("issue_aggr_id", 32'({fsync_aggr_o, fsync_id_o}), 32'(ei));
                end
            end
            if (|wake_o || |error_o || unmatched_o) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got %0h expected none", {unmatched_o, error_o, wake_o});
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_pulses", 32'({unmatched_o, error_o, wake_o}), 32'(er));
                end
            end
        end
    end

    // Advance one cycle; requests granted in this cycle are dropped after the edge.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_ready_o;
        @(posedge clk);
        #1;
        req_valid_i = req_valid_i & ~acc;
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [IW-1:0] d);
        req_valid_i[i]        = 1'b1;
        req_aggr_i[i*AW +: AW] = a;
        req_id_i[i*IW +: IW]   = d;
    endtask

    task automatic rsp(input logic w, input logic e, input logic [AW-1:0] a,
                       input logic [IW-1:0] d, input logic [2*N:0] exp);
        fsync_wake_i = w; fsync_error_i = e; fsync_rsp_aggr_i = a; fsync_rsp_id_i = d;
        rsp_q.push_back(exp);
        tick();
        fsync_wake_i = 1'b0; fsync_error_i = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_fvalid"}, 32'(fsync_valid_o), 0);
        chk({tag, "_faggr"}, 32'(fsync_aggr_o), 0);
        chk({tag, "_fid"}, 32'(fsync_id_o), 0);
        chk({tag, "_pulses"}, 32'({unmatched_o, error_o, wake_o}), 0);
        chk({tag, "_pending"}, 32'(pending_o), 0);
    endtask

    initial begin
        rst_ni = 1'b0; req_valid_i = '0; req_aggr_i = '0; req_id_i = '0;
        fsync_ready_i = 1'b0; fsync_wake_i = 1'b0; fsync_error_i = 1'b0;
        fsync_rsp_aggr_i = '0; fsync_rsp_id_i = '0;

        // Reset: ready gated, all outputs zero
        req_valid_i = 4'b0001;
        #1 chk("ready_in_reset", 32'(req_ready_o), 0);
        req_valid_i = '0;
        tick(); tick();
        chk_idle_outputs("reset");
        rst_ni = 1'b1;

        // Single request then wake
        fsync_ready_i = 1'b1;
        set_req(0, 6'd0, 5'd0);
        iss_q.push_back({6'd0, 5'd0});
        #1 chk("single_ready", 32'(req_ready_o), 4'b0001);
        tick();
        chk("single_fvalid", 32'(fsync_valid_o), 1);
        chk("single_pending", 32'(pending_o), 4'b0001);
        tick();
        rsp(1'b1, 1'b0, 6'd0, 5'd0, 9'b0_0000_0001);
        chk("single_wake", 32'(wake_o), 4'b0001);
        chk("single_pending_fall", 32'(pending_o), 0);
        tick();

        // rr_ptr=1 with requesters 0 and 2 valid: order 2, 0
        set_req(0, 6'd3, 5'd10);
        set_req(2, 6'd3, 5'd12);
        iss_q.push_back({6'd3, 5'd12});
        iss_q.push_back({6'd3, 5'd10});
        #1 chk("rr_first", 32'(req_ready_o), 4'b0100);
        tick();
        chk("rr_second", 32'(req_ready_o), 4'b0001);
        tick(); tick(); tick();
        chk("rr_pending", 32'(pending_o), 4'b0101);
        rsp(1'b1, 1'b0, 6'd3, 5'd10, 9'b0_0000_0001);
        chk("wake_req0", 32'(wake_o), 4'b0001);
        rsp(1'b1, 1'b1, 6'd3, 5'd12, 9'b0_0100_0000);
        chk("err_prio_err", 32'(error_o), 4'b0100);
        chk("err_prio_wake", 32'(wake_o), 0);
        rsp(1'b1, 1'b0, 6'd3, 5'd9, 9'b1_0000_0000);
        chk("nomatch_unm", 32'(unmatched_o), 1);
        chk("nomatch_pulses", 32'({error_o, wake_o}), 0);
        tick();

        // Full round from reset: order 0,1,2,3 back-to-back
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 6'd5, 5'(i));
            iss_q.push_back({6'd5, 5'(i)});
        end
        for (int k = 0; k < N; k++) begin
            #1 chk($sformatf("b2b_grant%0d", k), 32'(req_ready_o), 32'(1) << k);
            tick();
        end
        tick();
        chk("b2b_pending", 32'(pending_o), 4'b1111);

        // Reset discards WAIT state; then backpressure
        rst_ni = 1'b0; tick();
        chk("discard_pending", 32'(pending_o), 0);
        rst_ni = 1'b1;
        fsync_ready_i = 1'b0;
        set_req(0, 6'd2, 5'd4);
        set_req(2, 6'd2, 5'd6);
        iss_q.push_back({6'd2, 5'd4});
        iss_q.push_back({6'd2, 5'd6});
        #1 chk("bp_first", 32'(req_ready_o), 4'b0001);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold", 32'({fsync_valid_o, fsync_aggr_o, fsync_id_o}), {1'b1, 6'd2, 5'd4});
            chk("bp_noready", 32'(req_ready_o), 0);
            tick();
        end
        fsync_ready_i = 1'b1;
        #1 chk("bp_release", 32'(req_ready_o), 4'b0100);
        tick();
        chk("bp_next", 32'({fsync_valid_o, fsync_id_o}), {1'b1, 5'd6});
        tick();

        // Shared barrier: requesters 3 then 1 (rr_ptr=3), one wake for both
        set_req(1, 6'd1, 5'd7);
        set_req(3, 6'd1, 5'd7);
        iss_q.push_back({6'd1, 5'd7});
        iss_q.push_back({6'd1, 5'd7});
        #1 chk("shared_first", 32'(req_ready_o), 4'b1000);
        tick();
        chk("shared_second", 32'(req_ready_o), 4'b0010);
        tick(); tick();
        rsp(1'b1, 1'b0, 6'd1, 5'd7, 9'b0_0000_1010);
        chk("shared_wake", 32'(wake_o), 4'b1010);
        chk("shared_pending", 32'(pending_o), 4'b0101);

        // Reset with requester 0 in WAIT and requester 1 in ISSUE
        fsync_ready_i = 1'b0;
        set_req(1, 6'd4, 5'd8);
        #1 chk("mid_ready", 32'(req_ready_o), 4'b0010);
        tick();
        chk("mid_pending", 32'(pending_o), 4'b0111);
        rst_ni = 1'b0;
        tick();
        chk_idle_outputs("midrst");
        chk("midrst_ready", 32'(req_ready_o), 0);
        rst_ni = 1'b1;
        rsp(1'b1, 1'b0, 6'd2, 5'd4, 9'b1_0000_0000);
        chk("stale_unm", 32'(unmatched_o), 1);
        chk("stale_wake", 32'(wake_o), 0);
        fsync_ready_i = 1'b1;
        set_req(1, 6'd6, 5'd1);
        set_req(3, 6'd6, 5'd3);
        iss_q.push_back({6'd6, 5'd1});
        iss_q.push_back({6'd6, 5'd3});
        #1 chk("resume_rr0", 32'(req_ready_o), 4'b0010);
        tick(); tick(); tick(); tick();

        chk("iss_q_drained", 32'(iss_q.size()), 0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
